i2c_target_regs: RTL and testbench
==================================

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 Parameter: SLV_ADDR, default 7'h50, 7-bit I2C target address this block answers to.
REQ-002 Parameter: SYNC_STAGES, default 2, synchronizer depth on scl_i/sda_i.
REQ-003 clk  input  1  system clock; all logic on rising edge; one clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 scl_i  input  1  I2C SCL pin level, asynchronous to clk.
REQ-006 sda_i  input  1  I2C SDA pin level, asynchronous to clk.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain), 0 = release.
REQ-008 loc_addr  input  4  local read address into register bank.
REQ-009 loc_rdata  output  8  register bank contents at loc_addr, combinational.
REQ-010 wr_strobe  output  1  one-cycle pulse when the I2C side writes a register.
REQ-011 busy  output  1  high from START to STOP (any address).

Function
REQ-012 Bank SHALL be 16 x 8-bit registers plus a 4-bit pointer ptr.
REQ-013 scl_i/sda_i SHALL pass through SYNC_STAGES flops plus one edge-detect flop; a pin edge is recognized SYNC_STAGES+1 clk cycles after it occurs; clk >= 8x SCL.
REQ-014 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while SCL high; both SHALL be honoured from every state.
REQ-015 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-016 START -> ADDR, bit counter cleared; repeated START behaves identically, ptr retained.
REQ-017 STOP -> IDLE, sda_oe released in the same cycle the STOP is recognized.
REQ-018 Data bits SHALL be sampled on recognized SCL rising edge, MSB first; sda_oe SHALL change only on recognized SCL falling edge.
REQ-019 ADDR: after 8 bits, address[7:1]==SLV_ADDR -> ADDR_ACK; mismatch -> WAIT_STOP with sda_oe=0.
REQ-020 ACK: sda_oe=1 from the falling edge after bit 8 until the next falling edge.
REQ-021 After ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RDATA, loading shifter with regs[ptr].
REQ-022 PTR: received byte[3:0] -> ptr, bits[7:4] ignored; ACK; -> WDATA.
REQ-023 WDATA: received byte -> regs[ptr] on the SCL rising edge of bit 8, wr_strobe pulses that cycle, ptr increments mod 16 (15 -> 0); ACK; repeat.
REQ-024 RDATA: drive shifter MSB-first (sda_oe = ~bit); after bit 8 release SDA and sample master ACK on next rising edge.
REQ-025 Master ACK (SDA low) -> ptr increments mod 16, load regs[ptr], next RDATA; NACK -> WAIT_STOP, SDA released.
REQ-026 WAIT_STOP: ignore SCL, sda_oe=0, leave only on START or STOP.
REQ-027 loc_rdata reads the bank while the I2C side writes; a same-cycle write to loc_addr SHALL show old data that cycle, new data the next.

Reset
REQ-028 reset SHALL force: state IDLE, sda_oe=0, wr_strobe=0, busy=0, ptr=0, all 16 registers 8'h00, synchronizer flops to 1 (idle bus).
REQ-029 reset mid-transaction SHALL release SDA on the cycle after reset is sampled; the interrupted write is discarded if bit 8 was not yet sampled.

Structure
REQ-030 Shared package i2c_pkg SHALL hold the state enum, I2C_ADDR_W=7, and default SLV_ADDR.
REQ-031 One sub-module i2c_sync_edge (synchronizer + rise/fall pulse outputs), instantiated for SCL and SDA.

Verification
REQ-032 Write 7'h50+W, ptr 8'h03, data 8'hA5, 8'h3C, STOP -> three ACKs, regs[3]=A5, regs[4]=3C, two wr_strobe pulses, busy low after STOP.
REQ-033 Write ptr 8'h0F, data 8'h11, 8'h22 -> regs[15]=11, regs[0]=22 (wrap), ptr ends 1.
REQ-034 Address 7'h51 -> no ACK (sda_oe stays 0 entire byte), registers unchanged, WAIT_STOP until STOP.
REQ-035 Write ptr 8'h03, repeated START, 7'h50+R, master ACK then NACK -> SDA carries A5 then 3C, released after NACK.
REQ-036 Assert reset during bit 5 of a WDATA byte -> sda_oe=0 next cycle, all registers 00, next transaction ACKed normally.
REQ-037 STOP mid-byte during RDATA -> SDA released same cycle, state IDLE, no ptr change.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: FSM state encoding,
// address width, default target address and pointer arithmetic.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam logic [I2C_ADDR_W-1:0] DEF_SLV_ADDR = 7'h50;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_WAIT_STOP = 4'd9
    } i2c_state_e;

    // Register pointer wraps 15 -> 0.
    function automatic logic [3:0] ptr_next(input logic [3:0] p);
        return p + 4'd1;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for an asynchronous bus pin with one extra flop
// for rise/fall detection. Flops reset to 1 so an idle bus shows no edge.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic [STAGES:0]   chain_s;
    logic              prev_q;
    logic              prev_d;

    assign chain_s = {sync_q, d_i};

    // Next state of the synchronizer chain and the edge-detect flop.
    always_comb begin
        sync_d = chain_s[STAGES-1:0];
        prev_d = sync_q[STAGES-1];
    end

    // Synchronizer and edge flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{1'b1}};
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a 16 x 8-bit register bank with an auto-incrementing
// pointer; the local side reads the bank combinationally.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLV_ADDR    = DEF_SLV_ADDR,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [3:0] loc_addr,
    output logic [7:0] loc_rdata,
    output logic       wr_strobe,
    output logic       busy
);

    logic scl_lvl_s, scl_rise_s, scl_fall_s;
    logic sda_lvl_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s, rx_bit_s, rx_last_s, ack_go_s;
    logic [7:0] rx_byte_s;

    i2c_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [3:0] ptr_q, ptr_d;
    logic [7:0] regs_q [16];
    logic [7:0] regs_d [16];
    logic       sda_oe_q, sda_oe_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic       busy_q, busy_d;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .reset(reset), .d_i(scl_i),
        .level_o(scl_lvl_s), .rise_o(scl_rise_s), .fall_o(scl_fall_s)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .reset(reset), .d_i(sda_i),
        .level_o(sda_lvl_s), .rise_o(sda_rise_s), .fall_o(sda_fall_s)
    );

    assign start_s   = sda_fall_s & scl_lvl_s;
    assign stop_s    = sda_rise_s & scl_lvl_s;
    assign rx_byte_s = {shift_q, sda_lvl_s};
    assign rx_bit_s  = scl_rise_s && (bit_cnt_q < 4'd8);
    assign rx_last_s = scl_rise_s && (bit_cnt_q == 4'd7);
    assign ack_go_s  = scl_fall_s && (bit_cnt_q == 4'd8);

    // Protocol FSM; START/STOP override every state.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        regs_d      = regs_q;
        sda_oe_d    = sda_oe_q;
        wr_strobe_d = 1'b0;
        busy_d      = busy_q;
        if (stop_s) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (start_s) begin
            state_d   = ST_ADDR;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (rx_bit_s) begin
                        shift_d   = rx_byte_s[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (rx_last_s && state_q == ST_ADDR) begin
                            state_d = (rx_byte_s[7:1] != SLV_ADDR) ? ST_WAIT_STOP : ST_ADDR;
                        end else if (rx_last_s && state_q == ST_PTR) begin
                            ptr_d = rx_byte_s[3:0];
                        end else if (rx_last_s) begin
                            regs_d[ptr_q] = rx_byte_s;
                            wr_strobe_d   = 1'b1;
                            ptr_d         = ptr_next(ptr_q);
                        end else begin
                            state_d = state_q;
                        end
                    end else if (ack_go_s) begin
                        // The ACK state for each receive state is the next encoding.
                        state_d  = i2c_state_e'(state_q + 4'd1);
                        sda_oe_d = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_s) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[0]) begin
                            state_d  = ST_RDATA;
                            shift_d  = regs_q[ptr_q][6:0];
                            sda_oe_d = ~regs_q[ptr_q][7];
                        end else begin
                            state_d  = ST_PTR;
                            sda_oe_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_ADDR_ACK;
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall_s) begin
                        state_d   = ST_WDATA;
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise_s && bit_cnt_q < 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_s && bit_cnt_q == 4'd8) begin
                        state_d  = ST_RDATA_ACK;
                        sda_oe_d = 1'b0;
                    end else if (scl_fall_s && bit_cnt_q != 4'd0) begin
                        shift_d  = {shift_q[5:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end else begin
                        state_d = ST_RDATA;
                    end
                end
                ST_RDATA_ACK: begin
                    // bit_cnt 9 marks "master ACK seen, load next byte on fall".
                    if (scl_rise_s && bit_cnt_q == 4'd8) begin
                        if (sda_lvl_s) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            ptr_d     = ptr_next(ptr_q);
                            bit_cnt_d = 4'd9;
                        end
                    end else if (scl_fall_s && bit_cnt_q == 4'd9) begin
                        state_d   = ST_RDATA;
                        bit_cnt_d = 4'd0;
                        shift_d   = regs_q[ptr_q][6:0];
                        sda_oe_d  = ~regs_q[ptr_q][7];
                    end else begin
                        state_d = ST_RDATA_ACK;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State, bank and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 7'h00;
            ptr_q       <= 4'd0;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            wr_strobe_q <= wr_strobe_d;
            busy_q      <= busy_d;
            regs_q      <= regs_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign wr_strobe = wr_strobe_q;
    assign busy      = busy_q;
    assign loc_rdata = regs_q[loc_addr];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: an I2C master model on an open-drain
// SDA line, register checks through the local read port.
module tb_i2c_target_regs;

    localparam int Q = 8;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic       wr_strobe;
    logic       busy;
    logic [3:0] loc_addr = 4'd0;
    logic [7:0] loc_rdata;

    int   n_cmp = 0;
    int   n_err = 0;
    int   strobe_cnt = 0;
    int   oe_bad = 0;
    logic oe_any = 1'b0;
    logic oe_prev = 1'b0;
    logic strobe_chk_en = 1'b0;
    logic [7:0] prev_rdata = 8'h00;

    rd_vec_t vecs[7];

    always #5 clk = ~clk;
    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_regs #(.SLV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .scl_i(scl_m), .sda_i(sda_bus),
        .sda_oe(sda_oe), .loc_addr(loc_addr), .loc_rdata(loc_rdata),
        .wr_strobe(wr_strobe), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic rd);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q / 2);
        rd = sda_bus;
        wait_clk(Q / 2);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d, output logic ack_line);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(~mack, r);
        ack_line = r;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    // Bus monitor: strobe counting, SDA-change-while-SCL-high detection,
    // and old/new data around the first write of the first transaction.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) strobe_cnt++;
        if (sda_oe === 1'b1) oe_any = 1'b1;
        if (sda_oe !== oe_prev && scl_m) oe_bad++;
        oe_prev = sda_oe;
        if (strobe_chk_en && wr_strobe === 1'b1) begin
            check("same_cycle_old", {24'h0, prev_rdata}, 32'h00);
            check("next_cycle_new", {24'h0, loc_rdata}, 32'hA5);
            strobe_chk_en = 1'b0;
        end
        prev_rdata = loc_rdata;
    end

    initial begin
        logic       ack;
        logic       r0, r1;
        logic [7:0] d;

        vecs[0] = '{4'd3,  8'hA5};
        vecs[1] = '{4'd4,  8'h3C};
        vecs[2] = '{4'd15, 8'h11};
        vecs[3] = '{4'd0,  8'h22};
        vecs[4] = '{4'd1,  8'h77};
        vecs[5] = '{4'd2,  8'h00};
        vecs[6] = '{4'd14, 8'h00};

        wait_clk(4);
        reset = 1'b0;
        wait_clk(2);
        check("rst_sda_oe", {31'h0, sda_oe}, 32'h0);
        check("rst_wr_strobe", {31'h0, wr_strobe}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_reg0", {24'h0, loc_rdata}, 32'h00);

        // Write A5, 3C from pointer 3.
        loc_addr = 4'd3;
        strobe_cnt = 0;
        strobe_chk_en = 1'b1;
        i2c_start();
        check("t1_busy_start", {31'h0, busy}, 32'h1);
        send_byte(8'hA0, ack); check("t1_ack_addr", {31'h0, ack}, 32'h1);
        send_byte(8'h03, ack); check("t1_ack_ptr", {31'h0, ack}, 32'h1);
        send_byte(8'hA5, ack); check("t1_ack_d0", {31'h0, ack}, 32'h1);
        send_byte(8'h3C, ack); check("t1_ack_d1", {31'h0, ack}, 32'h1);
        check("t1_busy_mid", {31'h0, busy}, 32'h1);
        i2c_stop();
        check("t1_busy_stop", {31'h0, busy}, 32'h0);
        check("t1_strobes", strobe_cnt, 32'd2);
        check("t1_strobe_chk_done", {31'h0, strobe_chk_en}, 32'h0);

        // Reg 1 = 77 so the pointer position after the wrap test is visible.
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h01, ack);
        send_byte(8'h77, ack); check("t1b_ack", {31'h0, ack}, 32'h1);
        i2c_stop();

        // Pointer wrap 15 -> 0, then read at the resulting pointer (1).
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h0F, ack);
        send_byte(8'h11, ack);
        send_byte(8'h22, ack); check("t2_ack_d1", {31'h0, ack}, 32'h1);
        i2c_stop();
        i2c_start();
        send_byte(8'hA1, ack); check("t2_ack_rd_addr", {31'h0, ack}, 32'h1);
        recv_byte(1'b0, d, r0);
        check("t2_ptr_after_wrap", {24'h0, d}, 32'h77);
        i2c_stop();

        // Foreign address: never ACKed, rest of transaction ignored.
        i2c_start();
        oe_any = 1'b0;
        send_byte(8'hA2, ack);
        check("t3_nack_addr", {31'h0, ack}, 32'h0);
        check("t3_oe_quiet", {31'h0, oe_any}, 32'h0);
        send_byte(8'h03, ack);
        check("t3_nack_data", {31'h0, ack}, 32'h0);
        check("t3_busy", {31'h0, busy}, 32'h1);
        i2c_stop();
        check("t3_busy_stop", {31'h0, busy}, 32'h0);

        // Set pointer, repeated START, read two bytes (ACK then NACK).
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        i2c_start();
        send_byte(8'hA1, ack); check("t4_ack_rd_addr", {31'h0, ack}, 32'h1);
        recv_byte(1'b1, d, r0);
        check("t4_rd0", {24'h0, d}, 32'hA5);
        recv_byte(1'b0, d, r0);
        check("t4_rd1", {24'h0, d}, 32'h3C);
        check("t4_nack_line", {31'h0, r0}, 32'h1);
        check("t4_oe_released", {31'h0, sda_oe}, 32'h0);
        i2c_stop();

        // STOP in the middle of a read byte (A5 = 1,0,1,...).
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        i2c_start();
        send_byte(8'hA1, ack);
        bit_xfer(1'b1, r0);
        bit_xfer(1'b1, r1);
        check("t5_bit7", {31'h0, r0}, 32'h1);
        check("t5_bit6", {31'h0, r1}, 32'h0);
        i2c_stop();
        check("t5_oe_stop", {31'h0, sda_oe}, 32'h0);
        check("t5_busy_stop", {31'h0, busy}, 32'h0);
        i2c_start();
        send_byte(8'hA1, ack);
        recv_byte(1'b0, d, r0);
        check("t5_ptr_kept", {24'h0, d}, 32'hA5);
        i2c_stop();

        for (int i = 0; i < 7; i++) begin
            loc_addr = vecs[i].addr;
            wait_clk(1);
            check($sformatf("bank_reg%0d", vecs[i].addr), {24'h0, loc_rdata}, {24'h0, vecs[i].exp});
        end

        // Reset while SCL is high on bit 5 of a data byte (5A: bit 5 = 1).
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h05, ack);
        for (int i = 7; i >= 4; i--) bit_xfer(((8'h5A >> i) & 8'h01) != 8'h00, r0);
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(2);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        wait_clk(1);
        check("t6_oe_after_reset", {31'h0, sda_oe}, 32'h0);
        check("t6_busy_after_reset", {31'h0, busy}, 32'h0);
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        for (int i = 0; i < 16; i++) begin
            loc_addr = 4'(i);
            wait_clk(1);
            check($sformatf("t6_zero_reg%0d", i), {24'h0, loc_rdata}, 32'h00);
        end
        i2c_start();
        send_byte(8'hA0, ack); check("t6_ack_addr", {31'h0, ack}, 32'h1);
        send_byte(8'h00, ack); check("t6_ack_ptr", {31'h0, ack}, 32'h1);
        send_byte(8'h5A, ack); check("t6_ack_data", {31'h0, ack}, 32'h1);
        i2c_stop();
        loc_addr = 4'd0;
        wait_clk(1);
        check("t6_reg0", {24'h0, loc_rdata}, 32'h5A);

        check("oe_only_scl_low", oe_bad, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
